// File: rtl/multdiv_sequencer_pkg.sv
// Shared decode constants, field positions and FSM encoding for the mul/div sequencer.
package multdiv_sequencer_pkg;

    localparam logic [4:0] OPC_RTYPE = 5'b00000;
    localparam logic [4:0] ALUOP_MUL = 5'b00110;
    localparam logic [4:0] ALUOP_DIV = 5'b00111;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 27;
    localparam int RD_HI    = 26;
    localparam int RD_LO    = 22;
    localparam int RS_HI    = 21;
    localparam int RS_LO    = 17;
    localparam int RT_HI    = 16;
    localparam int RT_LO    = 12;
    localparam int ALUOP_HI = 6;
    localparam int ALUOP_LO = 2;

    localparam int TIMEOUT_DEF     = 64;
    localparam int EXC_MUL_DEF     = 4;
    localparam int EXC_DIV_DEF     = 5;
    localparam int RSTATUS_REG_DEF = 30;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_BUSY  = 2'd2,
        ST_WB    = 2'd3
    } md_state_t;

endpackage

// File: rtl/multdiv_insn_decode.sv
// Purpose: split an instruction word into mul/div flags and register fields.
// Latency: purely combinational.
// Backpressure: none; no state.
module multdiv_insn_decode
    import multdiv_sequencer_pkg::*;
(
    input  logic [31:0] insn,
    output logic        is_mul,
    output logic        is_div,
    output logic [4:0]  rd,
    output logic [4:0]  rs,
    output logic [4:0]  rt
);

    logic [4:0] opcode;
    logic [4:0] aluop;
    logic       unused_bits;

    assign opcode = insn[OPC_HI:OPC_LO];
    assign aluop  = insn[ALUOP_HI:ALUOP_LO];
    assign rd     = insn[RD_HI:RD_LO];
    assign rs     = insn[RS_HI:RS_LO];
    assign rt     = insn[RT_HI:RT_LO];

    assign is_mul = (opcode == OPC_RTYPE) && (aluop == ALUOP_MUL);
    assign is_div = (opcode == OPC_RTYPE) && (aluop == ALUOP_DIV);

    // shamt and low bits carry nothing the sequencer cares about
    assign unused_bits = ^{insn[11:7], insn[1:0]};

endmodule

// File: rtl/multdiv_sequencer.sv
// Purpose: issue one mul/div to the shared unit and write its result back on an idle regfile port.
// Latency: accept at edge N, start pulse in cycle N+1, earliest regfile write in cycle N+3.
// Backpressure: holds in WB while the main pipe owns the write port; stalls F/D on hazards.
module multdiv_sequencer
    import multdiv_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int EXC_MUL_CODE   = EXC_MUL_DEF,
    parameter int EXC_DIV_CODE   = EXC_DIV_DEF,
    parameter int RSTATUS_REG    = RSTATUS_REG_DEF
)(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dx_insn,
    input  logic        dx_valid,
    input  logic [31:0] dx_operand_a,
    input  logic [31:0] dx_operand_b,
    input  logic [31:0] fd_insn,
    input  logic        md_resultRDY,
    input  logic        md_exception,
    input  logic [31:0] md_result,
    input  logic        pipe_wb_we,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic [31:0] md_operand_a,
    output logic [31:0] md_operand_b,
    output logic        md_wb_we,
    output logic [4:0]  md_wb_rd,
    output logic [31:0] md_wb_data,
    output logic        stall,
    output logic        busy,
    output logic        timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [4:0]       RSTATUS  = 5'(RSTATUS_REG);

    md_state_t        state_q, state_d;
    logic             op_div_q, exc_q, timeout_err_q;
    logic [4:0]       rd_q, wb_rd_q;
    logic [31:0]      opa_q, opb_q, wb_data_q;
    logic [CNT_W-1:0] cnt_q;

    logic             dx_is_mul, dx_is_div, fd_is_mul, fd_is_div;
    logic [4:0]       dx_rd, dx_rs_unused, dx_rt_unused, fd_rd, fd_rs, fd_rt;
    logic             accept, timeout_hit, wb_needed, hit_rd, hit_exc;
    logic [31:0]      exc_code;

    multdiv_insn_decode u_dx_dec (
        .insn   (dx_insn),
        .is_mul (dx_is_mul),
        .is_div (dx_is_div),
        .rd     (dx_rd),
        .rs     (dx_rs_unused),
        .rt     (dx_rt_unused)
    );

    multdiv_insn_decode u_fd_dec (
        .insn   (fd_insn),
        .is_mul (fd_is_mul),
        .is_div (fd_is_div),
        .rd     (fd_rd),
        .rs     (fd_rs),
        .rt     (fd_rt)
    );

    assign accept      = (state_q == ST_IDLE) && dx_valid && (dx_is_mul || dx_is_div);
    assign timeout_hit = (cnt_q == CNT_LAST);
    // a non-faulting op targeting r0 has nothing to write
    assign wb_needed   = exc_q || (rd_q != 5'd0);
    assign exc_code    = op_div_q ? 32'(EXC_DIV_CODE) : 32'(EXC_MUL_CODE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept) state_d = ST_START;
            ST_START: state_d = ST_BUSY;
            ST_BUSY:  if (md_resultRDY || timeout_hit) state_d = ST_WB;
            ST_WB:    if (!pipe_wb_we || !wb_needed) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            op_div_q      <= 1'b0;
            exc_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            rd_q          <= '0;
            wb_rd_q       <= '0;
            opa_q         <= '0;
            opb_q         <= '0;
            wb_data_q     <= '0;
            cnt_q         <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        op_div_q <= dx_is_div;
                        rd_q     <= dx_rd;
                        opa_q    <= dx_operand_a;
                        opb_q    <= dx_operand_b;
                        exc_q    <= 1'b0;
                    end
                end
                ST_START: cnt_q <= '0;
                ST_BUSY: begin
                    if (md_resultRDY) begin
                        exc_q     <= md_exception;
                        wb_rd_q   <= md_exception ? RSTATUS : rd_q;
                        wb_data_q <= md_exception ? exc_code : md_result;
                    end else if (timeout_hit) begin
                        exc_q         <= 1'b1;
                        timeout_err_q <= 1'b1;
                        wb_rd_q       <= RSTATUS;
                        wb_data_q     <= exc_code;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // a pending fault retargets the write to rstatus, so that register joins the compare
    assign hit_rd  = (rd_q != 5'd0) && ((fd_rs == rd_q) || (fd_rt == rd_q) || (fd_rd == rd_q));
    assign hit_exc = (state_q == ST_WB) && exc_q &&
                     ((fd_rs == RSTATUS) || (fd_rt == RSTATUS) || (fd_rd == RSTATUS));

    assign busy         = (state_q != ST_IDLE);
    assign stall        = busy && (fd_is_mul || fd_is_div || hit_rd || hit_exc);
    assign ctrl_MULT    = (state_q == ST_START) && !op_div_q;
    assign ctrl_DIV     = (state_q == ST_START) && op_div_q;
    assign md_operand_a = opa_q;
    assign md_operand_b = opb_q;
    assign md_wb_we     = (state_q == ST_WB) && !pipe_wb_we && wb_needed;
    assign md_wb_rd     = wb_rd_q;
    assign md_wb_data   = wb_data_q;
    assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed bench for multdiv_sequencer; expected regfile writes queued at issue, checked at write.
module tb_multdiv_sequencer;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_MUL = 5'd6;
    localparam logic [4:0] ALU_DIV = 5'd7;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clock, reset;
    logic [31:0] dx_insn, dx_operand_a, dx_operand_b, fd_insn, md_result;
    logic        dx_valid, md_resultRDY, md_exception, pipe_wb_we;
    logic        ctrl_MULT, ctrl_DIV, md_wb_we, stall, busy, timeout_err;
    logic [31:0] md_operand_a, md_operand_b, md_wb_data;
    logic [4:0]  md_wb_rd;

    int  errors = 0;
    int  checks = 0;
    int  nwrites = 0;
    wb_t sb[$];

    multdiv_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .dx_insn      (dx_insn),
        .dx_valid     (dx_valid),
        .dx_operand_a (dx_operand_a),
        .dx_operand_b (dx_operand_b),
        .fd_insn      (fd_insn),
        .md_resultRDY (md_resultRDY),
        .md_exception (md_exception),
        .md_result    (md_result),
        .pipe_wb_we   (pipe_wb_we),
        .ctrl_MULT    (ctrl_MULT),
        .ctrl_DIV     (ctrl_DIV),
        .md_operand_a (md_operand_a),
        .md_operand_b (md_operand_b),
        .md_wb_we     (md_wb_we),
        .md_wb_rd     (md_wb_rd),
        .md_wb_data   (md_wb_data),
        .stall        (stall),
        .busy         (busy),
        .timeout_err  (timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] aluop);
        return {5'b00000, rd, rs, rt, 5'b00000, aluop, 2'b00};
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic smp();
        @(negedge clock);
    endtask

    // presents the op for one edge; returns in the START cycle
    task automatic issue(input logic [4:0] aluop, input logic [4:0] rd,
                         input logic [31:0] a, input logic [31:0] b);
        dx_insn      = rtype(rd, 5'd1, 5'd2, aluop);
        dx_valid     = 1'b1;
        dx_operand_a = a;
        dx_operand_b = b;
        cyc();
        dx_valid     = 1'b0;
        dx_insn      = 32'd0;
        dx_operand_a = 32'hffff_ffff;
        dx_operand_b = 32'hffff_ffff;
    endtask

    always @(negedge clock) begin
        if (md_wb_we) begin
            wb_t e;
            nwrites++;
            if (sb.size() == 0) begin
                chk("wb_unexpected", 32'(md_wb_we), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("wb_rd", 32'(md_wb_rd), 32'(e.rd));
                chk("wb_data", md_wb_data, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; dx_insn = '0; dx_valid = 1'b0; dx_operand_a = '0; dx_operand_b = '0;
        fd_insn = '0; md_resultRDY = 1'b0; md_exception = 1'b0; md_result = '0; pipe_wb_we = 1'b0;
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stall", 32'(stall), 0);
        chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 0);
        chk("rst_wb_we", 32'(md_wb_we), 0);
        chk("rst_wb_rd", 32'(md_wb_rd), 0);
        chk("rst_wb_data", md_wb_data, 0);
        chk("rst_opa", md_operand_a, 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        cyc();
        reset = 1'b1;
        cyc();

        // mul r3 = 6*7
        sb.push_back(wb_t'{rd: 5'd3, data: 32'd42});
        issue(ALU_MUL, 5'd3, 32'd6, 32'd7);
        smp();
        chk("t1_ctrl_mult", 32'(ctrl_MULT), 1);
        chk("t1_ctrl_div", 32'(ctrl_DIV), 0);
        chk("t1_opa", md_operand_a, 32'd6);
        chk("t1_opb", md_operand_b, 32'd7);
        cyc(); smp();
        chk("t1_pulse_once", 32'(ctrl_MULT), 0);
        chk("t1_busy", 32'(busy), 1);
        repeat (3) cyc();
        cyc(); md_resultRDY = 1'b1; md_result = 32'd42;
        cyc(); md_resultRDY = 1'b0; md_result = 32'hdead_beef;
        smp();
        chk("t1_wb_we", 32'(md_wb_we), 1);
        chk("t1_opa_hold", md_operand_a, 32'd6);
        cyc(); smp();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_stall", 32'(stall), 0);
        chk("t1_wb_off", 32'(md_wb_we), 0);

        // div r4 = 100/7 with F/D readers
        sb.push_back(wb_t'{rd: 5'd4, data: 32'd14});
        fd_insn = rtype(5'd5, 5'd4, 5'd1, ALU_ADD);
        issue(ALU_DIV, 5'd4, 32'd100, 32'd7);
        smp();
        chk("t2_ctrl_div", 32'(ctrl_DIV), 1);
        chk("t2_ctrl_mult", 32'(ctrl_MULT), 0);
        chk("t2_stall_rs_r4", 32'(stall), 1);
        cyc(); fd_insn = rtype(5'd7, 5'd5, 5'd6, ALU_ADD);
        smp();
        chk("t2_nostall_r5", 32'(stall), 0);
        cyc(); fd_insn = rtype(5'd0, 5'd0, 5'd0, ALU_MUL);
        smp();
        chk("t2_stall_struct", 32'(stall), 1);
        cyc(); fd_insn = rtype(5'd9, 5'd1, 5'd4, ALU_ADD);
        md_resultRDY = 1'b1; md_result = 32'd14;
        smp();
        chk("t2_stall_rt_r4", 32'(stall), 1);
        cyc(); md_resultRDY = 1'b0; md_result = 32'd0;
        smp();
        chk("t2_wb_we", 32'(md_wb_we), 1);
        chk("t2_stall_wb", 32'(stall), 1);
        cyc(); smp();
        chk("t2_stall_drop", 32'(stall), 0);
        fd_insn = 32'd0;

        // div by zero faults: r30 <- 5, r6 untouched
        sb.push_back(wb_t'{rd: 5'd30, data: 32'd5});
        issue(ALU_DIV, 5'd6, 32'd9, 32'd0);
        cyc(); md_resultRDY = 1'b1; md_exception = 1'b1; md_result = 32'd0;
        cyc(); md_resultRDY = 1'b0; md_exception = 1'b0;
        fd_insn = rtype(5'd1, 5'd30, 5'd2, ALU_ADD);
        smp();
        chk("t3_wb_we", 32'(md_wb_we), 1);
        chk("t3_stall_r30", 32'(stall), 1);
        chk("t3_timeout_clr", 32'(timeout_err), 0);
        cyc(); fd_insn = 32'd0;
        smp();
        chk("t3_idle", 32'(busy), 0);

        // write port busy for 3 cycles
        sb.push_back(wb_t'{rd: 5'd8, data: 32'd15});
        issue(ALU_MUL, 5'd8, 32'd3, 32'd5);
        cyc(); md_resultRDY = 1'b1; md_result = 32'd15; pipe_wb_we = 1'b1;
        cyc(); md_resultRDY = 1'b0; md_result = 32'd0;
        smp(); chk("t4_hold1", 32'(md_wb_we), 0);
        cyc(); smp(); chk("t4_hold2", 32'(md_wb_we), 0);
        cyc(); smp(); chk("t4_hold3", 32'(md_wb_we), 0);
        chk("t4_busy", 32'(busy), 1);
        cyc(); pipe_wb_we = 1'b0;
        smp(); chk("t4_release", 32'(md_wb_we), 1);
        cyc(); smp(); chk("t4_idle", 32'(busy), 0);

        // unit never answers: timeout abort
        sb.push_back(wb_t'{rd: 5'd30, data: 32'd4});
        issue(ALU_MUL, 5'd10, 32'd1, 32'd2);
        cyc(); smp();
        n = 1;
        chk("t5_busy", 32'(busy), 1);
        chk("t5_err_before", 32'(timeout_err), 0);
        while (!md_wb_we && n < 100) begin
            cyc(); smp();
            n++;
        end
        chk("t5_abort_cycle", 32'(n), 32'd65);
        chk("t5_timeout_err", 32'(timeout_err), 1);
        cyc();

        sb.push_back(wb_t'{rd: 5'd11, data: 32'd4});
        issue(ALU_MUL, 5'd11, 32'd2, 32'd2);
        cyc(); md_resultRDY = 1'b1; md_result = 32'd4;
        cyc(); md_resultRDY = 1'b0;
        smp();
        chk("t5b_wb_we", 32'(md_wb_we), 1);
        chk("t5b_sticky", 32'(timeout_err), 1);
        cyc();

        // reset while BUSY
        issue(ALU_MUL, 5'd12, 32'd5, 32'd5);
        smp(); chk("t6_ctrl", 32'(ctrl_MULT), 1);
        cyc(); fd_insn = rtype(5'd0, 5'd0, 5'd0, ALU_MUL);
        #1 chk("t6_stall_pre", 32'(stall), 1);
        reset = 1'b0; md_resultRDY = 1'b1; md_result = 32'd25;
        #1;
        chk("t6_busy", 32'(busy), 0);
        chk("t6_stall", 32'(stall), 0);
        chk("t6_ctrl_off", 32'({ctrl_MULT, ctrl_DIV}), 0);
        chk("t6_wb_we", 32'(md_wb_we), 0);
        chk("t6_timeout", 32'(timeout_err), 0);
        chk("t6_opa", md_operand_a, 0);
        chk("t6_wb_data", md_wb_data, 0);
        cyc(); cyc();
        reset = 1'b1;
        repeat (4) cyc();
        md_resultRDY = 1'b0; fd_insn = 32'd0;
        smp(); chk("t6_still_idle", 32'(busy), 0);

        sb.push_back(wb_t'{rd: 5'd13, data: 32'd25});
        issue(ALU_MUL, 5'd13, 32'd5, 32'd5);
        smp(); chk("t6b_ctrl", 32'(ctrl_MULT), 1);
        cyc(); md_resultRDY = 1'b1; md_result = 32'd25;
        cyc(); md_resultRDY = 1'b0;
        smp(); chk("t6b_wb_we", 32'(md_wb_we), 1);
        cyc(); cyc();

        chk("sb_empty", 32'(sb.size()), 0);
        chk("write_count", 32'(nwrites), 32'd7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
